tile_write_arbiter: RTL

//  Shares one 16-bit Avalon-MM write master among NUM_REQ tile writers (32x32-pixel tile streams).

---
 rtl/tile_write_arbiter_pkg.sv | 15 +
 rtl/tile_write_arbiter_if.sv | 28 ++
 rtl/tile_write_arbiter_rr_pick.sv | 27 ++
 rtl/tile_write_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/tile_write_arbiter_pkg.sv
// Shared definitions for the tile write path: arbiter state encoding and
// tile geometry constants also used by the tile writers.
package tile_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int unsigned TILE_W     = 32;
    localparam int unsigned TILE_H     = 32;
    localparam int unsigned TILE_BEATS = TILE_W * TILE_H;
    localparam int unsigned PIXEL_W    = 16;

endpackage

// File: rtl/tile_write_arbiter_if.sv
// Bundle of the requester-side and interconnect-side Avalon-MM write signals.
// The master modport is the arbiter's view; slave is the environment's view.
interface tile_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 16
);

    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_write_data;
    logic [NUM_REQ-1:0]        req_wait_request;
    logic [ADDR_W-1:0]         master_address;
    logic                      master_write;
    logic [DATA_W-1:0]         master_write_data;
    logic                      master_wait_request;

    modport master (
        input  req_address, req_write, req_write_data, master_wait_request,
        output req_wait_request, master_address, master_write, master_write_data
    );

    modport slave (
        output req_address, req_write, req_write_data, master_wait_request,
        input  req_wait_request, master_address, master_write, master_write_data
    );

endinterface

// File: rtl/tile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from ptr+1,
// wrapping around, with ptr itself checked last.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        any  = |req;
        idx  = '0;
        cand = '0;
        // Walk farthest offset first so the nearest requester overwrites last.
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tile_write_arbiter.sv
// Shares one Avalon-MM write master among NUM_REQ tile writers; each grant
// lasts one tile of BURST_LEN accepted writes, with an owner-idle watchdog.
module tile_write_arbiter
    import tile_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned ADDR_W       = 32,
    parameter  int unsigned DATA_W       = PIXEL_W,
    parameter  int unsigned BURST_LEN    = TILE_BEATS,
    parameter  int unsigned IDLE_TIMEOUT = 256,
    localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    tile_write_arbiter_if.master bus,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 tile_done,
    output logic                 timeout_err
);

    localparam int unsigned CNT_W  = $clog2(BURST_LEN) + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(IDLE_TIMEOUT - 1);

    arb_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_grant_id, w_grant_id_nxt;
    logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
    logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic              w_pick_any;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_granted;
    logic              w_owner_wr;
    logic              w_beat_ok;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req (bus.req_write),
        .ptr (r_rr_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    assign w_granted   = (r_state == ST_GRANT);
    assign w_owner_wr  = bus.req_write[r_grant_id];
    assign w_beat_ok   = w_granted && w_owner_wr && !bus.master_wait_request;
    assign grant_valid = w_granted;
    assign grant_id    = r_grant_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_idle_cnt_nxt = r_idle_cnt;
        tile_done      = 1'b0;
        timeout_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_grant_id_nxt = w_pick_idx;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_idle_cnt_nxt = w_owner_wr ? '0 : r_idle_cnt + 1'b1;
                if (w_beat_ok) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
                // Completion needs a write and timeout needs no write, so they are exclusive.
                if (w_beat_ok && r_beat_cnt == LAST_BEAT) begin
                    tile_done      = 1'b1;
                    w_rr_ptr_nxt   = r_grant_id;
                    w_beat_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (!w_owner_wr && r_idle_cnt == LAST_IDLE) begin
                    timeout_err    = 1'b1;
                    w_rr_ptr_nxt   = r_grant_id;
                    w_beat_cnt_nxt = '0;
                    w_idle_cnt_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.master_address    = '0;
        bus.master_write      = 1'b0;
        bus.master_write_data = '0;
        bus.req_wait_request  = '1;
        if (w_granted) begin
            bus.master_address               = bus.req_address[r_grant_id*ADDR_W +: ADDR_W];
            bus.master_write                 = w_owner_wr;
            bus.master_write_data            = bus.req_write_data[r_grant_id*DATA_W +: DATA_W];
            bus.req_wait_request[r_grant_id] = bus.master_wait_request;
        end
    end

endmodule
